pito_hart_scheduler: RTL and testbench

- Issue scheduler for the barrel RV32 core.
- Each cycle it selects which hart presents its next instruction to the fetch stage.
- Keeps a per-hart run state (OFF/RUN/SLEEP) driven by a host enable, retiring WFI instructions and pending interrupts.
- Sits between the CSR/interrupt logic and the instruction-fetch stage.
- Shares the single pipeline among up to PITO_HART_CNT harts in round-robin order.

---
 rtl/pito_hart_scheduler.sv | 127 ++++++++++++
 tb/tb_pito_hart_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pito_hart_scheduler.sv
// Round-robin hart issue scheduler for the barrel RV32 core with per-hart OFF/RUN/SLEEP tracking.
// Optional perf counters (idle_cycles_o, wfi_count_o) are enabled by defining PITO_HART_SCHED_PERF_EN.
module pito_hart_scheduler #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_HARTS-1:0]      hart_enable_i,
  input  logic [NUM_HARTS-1:0]      irq_pending_i,
  input  logic                      wfi_valid_i,
  input  logic [HART_CNT_WIDTH-1:0] wfi_hart_i,
  input  logic                      issue_ready_i,
  output logic                      issue_valid_o,
  output logic [HART_CNT_WIDTH-1:0] issue_hart_o,
  output logic [NUM_HARTS-1:0]      hart_run_o,
  output logic [NUM_HARTS-1:0]      hart_sleep_o,
`ifdef PITO_HART_SCHED_PERF_EN
  output logic [31:0]               idle_cycles_o,
  output logic [31:0]               wfi_count_o,
`endif
  output logic                      all_idle_o
);

  typedef enum logic [1:0] {HS_OFF, HS_RUN, HS_SLEEP} hart_state_e;

  hart_state_e                 state_p0   [NUM_HARTS];
  hart_state_e                 state_next [NUM_HARTS];
  logic [NUM_HARTS-1:0]        run_cur;
  logic [NUM_HARTS-1:0]        run_next;
  logic [NUM_HARTS-1:0]        sleep_next;
  logic [HART_CNT_WIDTH-1:0]   last_p0;
  logic [HART_CNT_WIDTH-1:0]   cand;
  logic [HART_CNT_WIDTH-1:0]   sel;
  logic                        found;
  logic                        upd;
  logic                        drop;

  function automatic logic [HART_CNT_WIDTH-1:0] ptr_inc(input logic [HART_CNT_WIDTH-1:0] p);
    if (int'(p) >= NUM_HARTS - 1) return '0;
    else return p + HART_CNT_WIDTH'(1);
  endfunction

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      state_next[h] = state_p0[h];
      if (!hart_enable_i[h]) begin
        state_next[h] = HS_OFF;
      end else begin
        case (state_p0[h])
          HS_OFF:   state_next[h] = HS_RUN;
          // A WFI racing with a pending interrupt retires as a NOP.
          HS_RUN:   if (wfi_valid_i && (int'(wfi_hart_i) == h) && !irq_pending_i[h])
                      state_next[h] = HS_SLEEP;
          HS_SLEEP: if (irq_pending_i[h]) state_next[h] = HS_RUN;
          default:  state_next[h] = HS_OFF;
        endcase
      end
      run_cur[h]    = (state_p0[h] == HS_RUN);
      run_next[h]   = (state_next[h] == HS_RUN);
      sleep_next[h] = (state_next[h] == HS_SLEEP);
    end
  end

  // Stage p0: per-hart state and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < NUM_HARTS; h++) state_p0[h] <= HS_OFF;
      hart_run_o   <= '0;
      hart_sleep_o <= '0;
      all_idle_o   <= 1'b1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) state_p0[h] <= state_next[h];
      hart_run_o   <= run_next;
      hart_sleep_o <= sleep_next;
      all_idle_o   <= ~|run_next;
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = last_p0;
    cand  = last_p0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      cand = ptr_inc(cand);
      if (!found && run_next[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign upd  = ~issue_valid_o | issue_ready_i;
  assign drop = issue_valid_o & ~run_next[issue_hart_o];

  // Stage p0: issue decision; a stalled hart that leaves RUN is withdrawn, search resumes next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_o <= 1'b0;
      issue_hart_o  <= '0;
      last_p0       <= HART_CNT_WIDTH'(NUM_HARTS - 1);
    end else if (upd) begin
      issue_valid_o <= found;
      if (found) begin
        issue_hart_o <= sel;
        last_p0      <= sel;
      end
    end else if (drop) begin
      issue_valid_o <= 1'b0;
    end
  end

`ifdef PITO_HART_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cycles_o <= '0;
      wfi_count_o   <= '0;
    end else begin
      if (!issue_valid_o && (idle_cycles_o != 32'hFFFF_FFFF))
        idle_cycles_o <= idle_cycles_o + 32'd1;
      if ((|(run_cur & sleep_next)) && (wfi_count_o != 32'hFFFF_FFFF))
        wfi_count_o <= wfi_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pito_hart_scheduler.sv
// Directed table-driven bench for pito_hart_scheduler (8-hart instance plus a 6-hart wrap instance).
module tb_pito_hart_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en, irq;
  logic       wv;
  logic [2:0] wh;
  logic       rdy;
  logic       valid;
  logic [2:0] hart;
  logic [7:0] run, sleep;
  logic       idle;

  logic [5:0] en6, irq6;
  logic       wv6;
  logic [2:0] wh6;
  logic       rdy6;
  logic       valid6;
  logic [2:0] hart6;
  logic [5:0] run6, sleep6;
  logic       idle6;

`ifdef PITO_HART_SCHED_PERF_EN
  logic [31:0] idle_cnt, wfi_cnt, idle_cnt6, wfi_cnt6;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pito_hart_scheduler #(.NUM_HARTS(8)) dut (
    .clk(clk), .rst(rst), .hart_enable_i(en), .irq_pending_i(irq),
    .wfi_valid_i(wv), .wfi_hart_i(wh), .issue_ready_i(rdy),
    .issue_valid_o(valid), .issue_hart_o(hart), .hart_run_o(run),
    .hart_sleep_o(sleep),
`ifdef PITO_HART_SCHED_PERF_EN
    .idle_cycles_o(idle_cnt), .wfi_count_o(wfi_cnt),
`endif
    .all_idle_o(idle)
  );

  pito_hart_scheduler #(.NUM_HARTS(6)) dut6 (
    .clk(clk), .rst(rst), .hart_enable_i(en6), .irq_pending_i(irq6),
    .wfi_valid_i(wv6), .wfi_hart_i(wh6), .issue_ready_i(rdy6),
    .issue_valid_o(valid6), .issue_hart_o(hart6), .hart_run_o(run6),
    .hart_sleep_o(sleep6),
`ifdef PITO_HART_SCHED_PERF_EN
    .idle_cycles_o(idle_cnt6), .wfi_count_o(wfi_cnt6),
`endif
    .all_idle_o(idle6)
  );

  typedef struct {
    logic [7:0] en;
    logic [7:0] irq;
    logic       wv;
    logic [2:0] wh;
    logic       rdy;
    logic [2:0] eh;
    logic [7:0] er;
    logic [7:0] es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] e, logic [7:0] i, logic w, logic [2:0] h,
                              logic r, logic [2:0] eh, logic [7:0] er, logic [7:0] es);
    vec_t v;
    v.en = e; v.irq = i; v.wv = w; v.wh = h; v.rdy = r; v.eh = eh; v.er = er; v.es = es;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] e, input logic [7:0] i, input logic w,
                       input logic [2:0] h, input logic r);
    en = e; irq = i; wv = w; wh = h; rdy = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    en6 = '0; irq6 = '0; wv6 = 1'b0; wh6 = '0; rdy6 = 1'b0;
    tick(); tick();
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_hart",  32'(hart),  32'd0);
    check("reset_run",   32'(run),   32'd0);
    check("reset_sleep", 32'(sleep), 32'd0);
    check("reset_idle",  32'(idle),  32'd1);
    rst = 1'b0;

    // Full round robin, WFI/wake on hart 3, 5-cycle stall on hart 5, WFI+irq race on hart 2.
    for (int k = 0; k < 10; k++) tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'(k % 8), 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 8'h00, 1, 3, 1, 3'd2, 8'hF7, 8'h08));
    tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'd4, 8'hF7, 8'h08));
    tbl.push_back(mk(8'hFF, 8'h08, 0, 0, 1, 3'd5, 8'hFF, 8'h00));
    for (int k = 6; k <= 13; k++) tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'(k % 8), 8'hFF, 8'h00));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 0, 3'd5, 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'd6, 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 8'h04, 1, 2, 1, 3'd7, 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'd0, 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'd1, 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 8'h00, 0, 0, 1, 3'd2, 8'hFF, 8'h00));

    foreach (tbl[n]) begin
      drive(tbl[n].en, tbl[n].irq, tbl[n].wv, tbl[n].wh, tbl[n].rdy);
      tick();
      check($sformatf("vec%0d_valid", n), 32'(valid), 32'd1);
      check($sformatf("vec%0d_hart", n),  32'(hart),  32'(tbl[n].eh));
      check($sformatf("vec%0d_run", n),   32'(run),   32'(tbl[n].er));
      check($sformatf("vec%0d_sleep", n), 32'(sleep), 32'(tbl[n].es));
      check($sformatf("vec%0d_idle", n),  32'(idle),  32'(tbl[n].er == 8'h00));
    end

    // Every hart retires a WFI in turn.
    for (int h = 0; h < 8; h++) begin
      drive(8'hFF, 8'h00, 1'b1, 3'(h), 1'b1);
      tick();
    end
    check("allwfi_valid", 32'(valid), 32'd0);
    check("allwfi_idle",  32'(idle),  32'd1);
    check("allwfi_sleep", 32'(sleep), 32'hFF);
    check("allwfi_run",   32'(run),   32'h00);
`ifdef PITO_HART_SCHED_PERF_EN
    check("wfi_count", wfi_cnt, 32'd9);
`endif
    drive(8'hFF, 8'h00, 1'b1, 3'd0, 1'b1);
    tick();
    check("wfi_on_sleep_ignored", 32'(sleep), 32'hFF);
    drive(8'hEF, 8'h00, 1'b0, 3'd0, 1'b1);
    tick();
    check("disable_sleep", 32'(sleep), 32'hEF);
    check("disable_run",   32'(run),   32'h00);
    drive(8'hEF, 8'hFF, 1'b0, 3'd0, 1'b1);
    tick();
    check("wake_run",   32'(run),   32'hEF);
    check("wake_sleep", 32'(sleep), 32'h00);
    check("wake_valid", 32'(valid), 32'd1);
    check("wake_idle",  32'(idle),  32'd0);

    // Presented hart sleeps while stalled, then reset lands mid-stall.
    rst = 1'b1; drive(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive(8'h01, 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    check("solo_valid", 32'(valid), 32'd1);
    check("solo_hart",  32'(hart),  32'd0);
    drive(8'h01, 8'h00, 1'b1, 3'd0, 1'b0);
    tick();
    check("stall_leave_valid", 32'(valid), 32'd0);
    check("stall_leave_sleep", 32'(sleep), 32'h01);
    drive(8'hFF, 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    check("resume_valid", 32'(valid), 32'd1);
    check("resume_hart",  32'(hart),  32'd1);
    tick();
    check("stall_hold_hart", 32'(hart), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_stall_valid", 32'(valid), 32'd0);
    check("rst_stall_hart",  32'(hart),  32'd0);
    check("rst_stall_run",   32'(run),   32'd0);
    check("rst_stall_sleep", 32'(sleep), 32'd0);
    check("rst_stall_idle",  32'(idle),  32'd1);
    rst = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    // Six-hart instance: three pre-enable cycles, then harts 0 and 5 alternate.
    for (int k = 0; k < 3; k++) tick();
    check("n6_pre_valid", 32'(valid6), 32'd0);
    en6 = 6'h21; rdy6 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("n6_valid%0d", k), 32'(valid6), 32'd1);
      check($sformatf("n6_hart%0d", k),  32'(hart6),  (k % 2 == 0) ? 32'd0 : 32'd5);
    end
`ifdef PITO_HART_SCHED_PERF_EN
    // Three disabled cycles plus the enable cycle itself, before the first issue.
    check("n6_idle_cycles", idle_cnt6, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
